// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in/serial-out transmit register.
// A WIDTH-bit word is captured on a valid/ready handshake. It is then
// shifted onto a 1-bit link, one bit for each clock where the bit strobe
// en is high.
// Optional feature macro: PISO_PARITY_EN. When defined, an even-parity bit
// (XOR of the word) follows the last data bit in an extra PAR state.
// Every output comes directly from a flop.
module piso_shift_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [CNT_W-1:0] bitcnt, bitcnt_d;
  logic             sout_d, sout_valid_d, frame_start_d, done_d, load_ready_d;
`ifdef PISO_PARITY_EN
  logic             par_bit, par_bit_d;
`endif

  // The bit that goes on the link first from a given register image.
  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through this block can infer a latch.
    state_d       = state;
    shreg_d       = shreg;
    bitcnt_d      = bitcnt;
    sout_d        = sout;
    sout_valid_d  = sout_valid;
    frame_start_d = frame_start;
    done_d        = 1'b0;
`ifdef PISO_PARITY_EN
    par_bit_d     = par_bit;
`endif
    case (state)
      IDLE: begin
        // en plays no part in accepting a word. Only the handshake matters.
        if (load_valid && load_ready) begin
          state_d       = SHIFT;
          shreg_d       = din;
          bitcnt_d      = '0;
          sout_d        = lead_bit(din);
          sout_valid_d  = 1'b1;
          frame_start_d = 1'b1;
`ifdef PISO_PARITY_EN
          par_bit_d     = ^din;
`endif
        end
      end
      SHIFT: begin
        if (en) begin
          frame_start_d = 1'b0;
          if (bitcnt == LAST_BIT) begin
`ifdef PISO_PARITY_EN
            state_d      = PAR;
            sout_d       = par_bit;
`else
            state_d      = IDLE;
            done_d       = 1'b1;
            sout_d       = 1'b0;
            sout_valid_d = 1'b0;
`endif
          end else begin
            shreg_d  = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
            bitcnt_d = bitcnt + 1'b1;
            sout_d   = lead_bit(shreg_d);
          end
        end
      end
`ifdef PISO_PARITY_EN
      PAR: begin
        if (en) begin
          state_d      = IDLE;
          done_d       = 1'b1;
          sout_d       = 1'b0;
          sout_valid_d = 1'b0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    // Words are accepted only in IDLE. That includes the cycle in which done is high.
    load_ready_d = (state_d == IDLE);
  end

  // Control and output registers. Reset overrides every input, including a handshake that arrives with it.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments only, so every flop samples pre-edge values.
    if (reset) begin
      state       <= IDLE;
      bitcnt      <= '0;
      sout        <= 1'b0;
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
      done        <= 1'b0;
      load_ready  <= 1'b1;
    end else begin
      state       <= state_d;
      bitcnt      <= bitcnt_d;
      sout        <= sout_d;
      sout_valid  <= sout_valid_d;
      frame_start <= frame_start_d;
      done        <= done_d;
      load_ready  <= load_ready_d;
    end
  end

  // Datapath registers. They are overwritten on every accept before they are read.
  always_ff @(posedge clk) begin
    // NOTE: the shift register is deliberately left out of reset. Nothing reads it outside SHIFT, and every frame loads it fresh.
    shreg   <= shreg_d;
`ifdef PISO_PARITY_EN
    par_bit <= par_bit_d;
`endif
  end

endmodule
